// File: rtl/direct_message_router.sv
`timescale 1ns/1ps
// direct_message_router: per-channel input FIFOs, round-robin candidate scan, and
// dispatch to a solver-chosen output channel or to the local unit. Define ROUTER_STATS_EN for counters.
module direct_message_router #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned CHANNEL_COUNT = 4,
  parameter int unsigned FIFO_DEPTH    = 2,
  localparam int unsigned MSG_W         = ADDRESS_WIDTH + 2,
  localparam int unsigned CHANNEL_WIDTH = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDRESS_WIDTH-1:0]         my_address,
  input  logic [MSG_W*CHANNEL_COUNT-1:0]   in_data,
  input  logic [CHANNEL_COUNT-1:0]         in_valid,
  output logic [CHANNEL_COUNT-1:0]         in_is_taken,
  output logic [MSG_W*CHANNEL_COUNT-1:0]   out_data,
  output logic [CHANNEL_COUNT-1:0]         out_valid,
  input  logic [CHANNEL_COUNT-1:0]         out_is_full,
  output logic [ADDRESS_WIDTH-1:0]         route_target,
  input  logic [CHANNEL_WIDTH-1:0]         route_result_idx,
`ifdef ROUTER_STATS_EN
  output logic [15:0]                      forward_count,
  output logic [15:0]                      stall_count,
`endif
  output logic [1:0]                       local_data,
  output logic                             local_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [MSG_W-1:0]         r_mem     [CHANNEL_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]         r_rd_ptr  [CHANNEL_COUNT];
  logic [PTR_W-1:0]         r_wr_ptr  [CHANNEL_COUNT];
  logic [CNT_W-1:0]         r_count   [CHANNEL_COUNT];
  logic [CHANNEL_WIDTH-1:0] r_rr;
  logic [CHANNEL_COUNT-1:0] r_out_valid;
  logic [MSG_W-1:0]         r_out_data [CHANNEL_COUNT];
  logic                     r_local_valid;
  logic [1:0]               r_local_data;

  logic                     w_found;
  logic [CHANNEL_WIDTH-1:0] w_cand;
  int unsigned              w_scan;
  logic [MSG_W-1:0]         w_head;
  logic                     w_is_local;
  logic                     w_k_ok;
  logic                     w_forward;
  logic                     w_stall;
  logic                     w_dispatch;
  logic [CHANNEL_COUNT-1:0] w_pop;

  // Acceptance looks only at the registered count, so a full FIFO never accepts while popping.
  always_comb begin
    in_is_taken = '0;
    for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
      in_is_taken[i] = in_valid[i] & ~reset & (32'(r_count[i]) < FIFO_DEPTH);
    end
  end

  // First non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_scan  = 0;
    for (int unsigned off = 0; off < CHANNEL_COUNT; off++) begin
      w_scan = (32'(r_rr) + off) % CHANNEL_COUNT;
      if (!w_found && (r_count[w_scan] != '0)) begin
        w_found = 1'b1;
        w_cand  = CHANNEL_WIDTH'(w_scan);
      end
    end
  end

  assign w_head       = r_mem[w_cand][r_rd_ptr[w_cand]];
  assign route_target = w_found ? w_head[MSG_W-1:2] : '0;
  assign w_is_local   = w_found && (w_head[MSG_W-1:2] == my_address);
  assign w_k_ok       = 32'(route_result_idx) < CHANNEL_COUNT;
  assign w_forward    = w_found && !w_is_local && w_k_ok && !out_is_full[route_result_idx];
  assign w_stall      = w_found && !w_is_local && !w_forward;
  assign w_dispatch   = w_is_local || w_forward;

  always_comb begin
    w_pop = '0;
    if (w_dispatch) w_pop[w_cand] = 1'b1;
  end

  // Storage array carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
      if (in_is_taken[i]) r_mem[i][r_wr_ptr[i]] <= in_data[i*MSG_W +: MSG_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        if (in_is_taken[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])       r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        if (in_is_taken[i] && !w_pop[i])      r_count[i] <= r_count[i] + CNT_W'(1);
        else if (!in_is_taken[i] && w_pop[i]) r_count[i] <= r_count[i] - CNT_W'(1);
      end
    end
  end

  // Registered dispatch; the pointer advances past the candidate even when it stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr          <= '0;
      r_out_valid   <= '0;
      r_local_valid <= 1'b0;
      r_local_data  <= '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) r_out_data[i] <= '0;
    end else begin
      r_out_valid   <= '0;
      r_local_valid <= 1'b0;
      if (w_found) r_rr <= CHANNEL_WIDTH'((32'(w_cand) + 1) % CHANNEL_COUNT);
      if (w_forward) begin
        r_out_valid[route_result_idx] <= 1'b1;
        r_out_data[route_result_idx]  <= w_head;
      end
      if (w_is_local) begin
        r_local_valid <= 1'b1;
        r_local_data  <= w_head[1:0];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < CHANNEL_COUNT; i++) out_data[i*MSG_W +: MSG_W] = r_out_data[i];
  end

  assign out_valid   = r_out_valid;
  assign local_valid = r_local_valid;
  assign local_data  = r_local_data;

`ifdef ROUTER_STATS_EN
  logic [15:0] r_fwd_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating event counters; local deliveries count as forwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_dispatch && (r_fwd_cnt != 16'hFFFF))  r_fwd_cnt   <= r_fwd_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF))   r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign forward_count = r_fwd_cnt;
  assign stall_count   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_direct_message_router.sv
`timescale 1ns/1ps
// Bench for direct_message_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_direct_message_router;
  localparam int unsigned AW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned MW = AW + 2;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   my_address;
  logic [MW*N-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_is_taken;
  logic [MW*N-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_is_full;
  logic [AW-1:0]   route_target;
  logic [CW-1:0]   route_result_idx;
  logic [1:0]      local_data;
  logic            local_valid;
`ifdef ROUTER_STATS_EN
  logic [15:0]     forward_count;
  logic [15:0]     stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int            solver_mode;
  logic [CW-1:0] fixed_idx;

  // Distance solver stand-in: fixed channel, or channel = low bits of the receiver.
  always_comb route_result_idx = (solver_mode == 1) ? route_target[CW-1:0] : fixed_idx;

  always #5 clk = ~clk;

  direct_message_router dut (
    .clk              (clk),
    .reset            (reset),
    .my_address       (my_address),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_is_taken      (in_is_taken),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_is_full      (out_is_full),
    .route_target     (route_target),
    .route_result_idx (route_result_idx),
`ifdef ROUTER_STATS_EN
    .forward_count    (forward_count),
    .stall_count      (stall_count),
`endif
    .local_data       (local_data),
    .local_valid      (local_valid)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per input channel.
  logic [MW-1:0] q [N][$];
  int            rr_m;
  logic [N-1:0]  e_out_valid;
  logic [MW-1:0] e_out_data [N];
  logic          e_local_valid;
  logic [1:0]    e_local_data;
  int            e_fwd;
  int            e_stall;
  bit            model_ready = 0;

  task automatic model_step();
    bit            found;
    int            c;
    int            k;
    logic [MW-1:0] h;
    logic [N-1:0]  exp_taken;
    logic [AW-1:0] exp_target;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        e_out_data[i] = '0;
      end
      rr_m = 0; e_out_valid = '0; e_local_valid = 1'b0; e_local_data = '0;
      e_fwd = 0; e_stall = 0;
      check("taken_in_reset", 32'(in_is_taken), 32'h0);
      check("target_in_reset", 32'(route_target), 32'h0);
      model_ready = 1;
      return;
    end
    found = 0; c = 0; h = '0;
    for (int off = 0; off < N; off++) begin
      if (!found && q[(rr_m + off) % N].size() > 0) begin
        found = 1;
        c = (rr_m + off) % N;
      end
    end
    if (found) h = q[c][0];
    exp_target = found ? h[MW-1:2] : '0;
    for (int i = 0; i < N; i++) exp_taken[i] = in_valid[i] && (q[i].size() < D);
    check("in_is_taken", 32'(in_is_taken), 32'(exp_taken));
    check("route_target", 32'(route_target), 32'(exp_target));
    e_out_valid = '0;
    e_local_valid = 1'b0;
    if (found) begin
      k = int'(route_result_idx);
      if (h[MW-1:2] == my_address) begin
        void'(q[c].pop_front());
        e_local_valid = 1'b1;
        e_local_data  = h[1:0];
        if (e_fwd < 65535) e_fwd++;
      end else if (k >= N || out_is_full[k]) begin
        if (e_stall < 65535) e_stall++;
      end else begin
        void'(q[c].pop_front());
        e_out_valid[k] = 1'b1;
        e_out_data[k]  = h;
        if (e_fwd < 65535) e_fwd++;
      end
      rr_m = (c + 1) % N;
    end
    for (int i = 0; i < N; i++) if (exp_taken[i]) q[i].push_back(in_data[i*MW +: MW]);
  endtask

  // Compare process: registered outputs just after each edge, model advanced at each falling edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (model_ready) begin
        check("out_valid", 32'(out_valid), 32'(e_out_valid));
        for (int i = 0; i < N; i++) check("out_data", 32'(out_data[i*MW +: MW]), 32'(e_out_data[i]));
        check("local_valid", 32'(local_valid), 32'(e_local_valid));
        check("local_data", 32'(local_data), 32'(e_local_data));
`ifdef ROUTER_STATS_EN
        check("forward_count", 32'(forward_count), 32'(e_fwd));
        check("stall_count", 32'(stall_count), 32'(e_stall));
`endif
      end
      @(negedge clk);
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_msg(input int ch, input logic [7:0] rcv, input logic o, input logic b);
    in_data[ch*MW +: MW] = {rcv, o, b};
  endtask

  initial begin
    logic [N-1:0] exp_oh;
    reset = 1'b1; my_address = 8'hAA; in_data = '0; in_valid = '0; out_is_full = '0;
    solver_mode = 0; fixed_idx = '0;
    repeat (10) tick();
    reset = 1'b0;
    #2;
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_out_data", 32'(out_data[31:0]), 32'h0);
    check("idle_local_valid", 32'(local_valid), 32'h0);
    check("idle_local_data", 32'(local_data), 32'h0);
    check("idle_route_target", 32'(route_target), 32'h0);
    check("idle_taken", 32'(in_is_taken), 32'h0);

    // Single forward: ch0 -> output 2.
    tick(); fixed_idx = 2'd2; set_msg(0, 8'hF0, 1'b1, 1'b0); in_valid = 4'b0001; #2;
    check("fwd_taken", 32'(in_is_taken), 32'h1);
    tick(); in_valid = '0; #2;
    check("fwd_not_early", 32'(out_valid), 32'h0);
    tick(); #2;
    check("fwd_out_valid", 32'(out_valid), 32'h4);
    check("fwd_out_data", 32'(out_data[2*MW +: MW]), 32'h3C2);
`ifdef ROUTER_STATS_EN
    check("fwd_count", 32'(forward_count), 32'd1);
`endif

    // Local delivery on ch3.
    set_msg(3, 8'hAA, 1'b0, 1'b1); in_valid = 4'b1000;
    tick(); in_valid = '0; #2;
    check("local_not_early", 32'(local_valid), 32'h0);
    tick(); #2;
    check("local_valid", 32'(local_valid), 32'h1);
    check("local_data", 32'(local_data), 32'h1);
    check("local_no_out", 32'(out_valid), 32'h0);

    // Round-robin under full load; receiver 0x10+i routes to output i.
    solver_mode = 1;
    for (int i = 0; i < N; i++) set_msg(i, 8'(8'h10 + i), i[0], 1'b1);
    for (int kk = 0; kk < 10; kk++) begin
      tick(); in_valid = 4'hF; #2;
      exp_oh = (kk < 2) ? 4'hF : 4'(1 << ((kk - 2) % 4));
      check("rr_taken", 32'(in_is_taken), 32'(exp_oh));
      check("rr_out_valid", 32'(out_valid), (kk < 2) ? 32'h0 : 32'(exp_oh));
    end
    in_valid = '0;
    repeat (8) tick();

    // Stall and skip: ch0 -> output 1 (full), ch1 -> output 3.
    reset = 1'b1; tick(); reset = 1'b0;
    set_msg(0, 8'h21, 1'b1, 1'b1); set_msg(1, 8'h23, 1'b0, 1'b0);
    tick(); in_valid = 4'b0011;
    tick(); in_valid = 4'b0010; out_is_full = 4'b0010;
    tick(); #2; check("stall_c2_out", 32'(out_valid), 32'h0);
    tick(); #2; check("stall_c3_out", 32'(out_valid), 32'h8);
    tick(); #2; check("stall_c4_out", 32'(out_valid), 32'h0);
    tick(); #2; check("stall_c5_out", 32'(out_valid), 32'h8);
    tick(); out_is_full = '0; #2;
    check("stall_c6_out", 32'(out_valid), 32'h0);
`ifdef ROUTER_STATS_EN
    check("stall_count3", 32'(stall_count), 32'd3);
`endif
    tick(); #2; check("stall_c7_out", 32'(out_valid), 32'h8);
    tick(); in_valid = '0; #2;
    check("stall_c8_out", 32'(out_valid), 32'h2);
    check("stall_c8_data", 32'(out_data[1*MW +: MW]), 32'h087);
    repeat (8) tick();

    // Reset mid-stream with one message in each FIFO.
    solver_mode = 0; fixed_idx = 2'd0;
    for (int i = 0; i < N; i++) set_msg(i, 8'(8'h30 + i), 1'b0, 1'b0);
    in_valid = 4'hF; out_is_full = 4'hF;
    tick(); in_valid = '0; out_is_full = '0;
    tick();
    check("pre_reset_out", 32'(out_valid), 32'h1);
    reset = 1'b1; in_valid = 4'hF;
    #1;
    check("async_reset_out", 32'(out_valid), 32'h0);
    check("async_reset_taken", 32'(in_is_taken), 32'h0);
    tick(); tick();
    in_valid = '0; reset = 1'b0;
    repeat (8) tick();
    check("post_reset_target", 32'(route_target), 32'h0);
    check("post_reset_out", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
